uart_tx: RTL

Byte-serial UART transmitter that drives the line consumed by `uart_rx`. It accepts bytes through a valid/ready handshake into a small internal FIFO, then serialises each byte onto `o_tx` as a frame. The frame has a start bit, 8 data bits LSB first, an optional parity bit, and 1 or 2 stop bits. Bit timing is derived from the same `I_CLK_FREQ`/`BAUDRATE` pair as the receiver, so a matched pair can loop back directly.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 66 ++++++
 rtl/uart_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity selectors and baud timing helper.
package uart_pkg;

  // FSM state encodings shared by the transmitter and receiver.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity selectors for the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clock cycles per serial bit, integer division.
  function automatic int bit_cycles(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO; full/empty are registered so the write side sees clean flags.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // A full FIFO ignores writes even if a pop frees a slot on the same edge.
  assign do_push = i_push && !full_q;
  assign do_pop  = i_pop && !empty_q;

  // Next pointers and the flags they imply; the extra MSB separates full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d == {~rd_ptr_d[AW], rd_ptr_d[AW-1:0]});
  end

  // Pointer and flag state, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array.
  // NOTE: the data array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign o_full  = full_q;
  assign o_empty = empty_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialised as start, 8 data LSB first, optional parity, stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int I_CLK_FREQ = 50_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int BIT_CYCLES = bit_cycles(I_CLK_FREQ, BAUDRATE);
  localparam int BW         = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  if (BIT_CYCLES < 2) begin : g_bad_baud
    $error("uart_tx: I_CLK_FREQ/BAUDRATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          bit_end;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_data;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_data  (i_data),
    .i_pop   (fifo_pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign fifo_push = i_data_valid && !fifo_full;
  assign bit_end   = (baud_q == BAUD_LAST);

  // Frame sequencing: next state, counters, shift register and the registered line level.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    fifo_pop = 1'b0;

    if (state_q != ST_IDLE) baud_d = bit_end ? '0 : baud_q + BW'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              state_d  = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop always enters START with fresh counters and a freshly loaded byte.
    if (fifo_pop) begin
      baud_d  = '0;
      bit_d   = '0;
      shift_d = fifo_data;
      par_d   = (PARITY == PAR_ODD) ? ~^fifo_data : ^fifo_data;
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase

    // Busy covers a frame in progress and a byte just written into an idle FIFO.
    busy_d = (state_d != ST_IDLE) || fifo_push;
  end

  // State registers; reset abandons any frame and parks the line high.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign o_tx    = tx_q;
  assign o_busy  = busy_q;
  assign o_ready = !fifo_full;

endmodule
